// File: rtl/lock_ctrl.sv
// Password-lock controller: assembles a 4-digit keypad entry, checks it against
// a stored code, and sequences the open and lockout intervals for the segment scanner.
module lock_ctrl #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int unsigned MAX_WRONG   = 3,
    parameter int unsigned OPEN_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] seg_1,
    output logic [3:0] seg_2,
    output logic [3:0] seg_3,
    output logic [3:0] seg_4,
    output logic [3:0] count_wrong,
    output logic       unlock,
    output logic       alarm,
    output logic       busy
);

    localparam int unsigned MAX_CYCLES = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [3:0] MAX_WRONG_V = 4'(MAX_WRONG);
    localparam logic [3:0] BLANK       = 4'hF;
    localparam logic [3:0] KEY_ENTER   = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CHECK   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t               state;
    logic [2:0]           digit_cnt;
    logic [TIMER_W-1:0]   timer;
    logic                 match_c;
    logic [3:0]           wrong_inc_c;

    // A short entry can never match, even if the blanks happen to line up.
    assign match_c     = (digit_cnt == 3'd4) && ({seg_4, seg_3, seg_2, seg_1} == PASSWORD);
    assign wrong_inc_c = count_wrong + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ENTRY;
            seg_1       <= BLANK;
            seg_2       <= BLANK;
            seg_3       <= BLANK;
            seg_4       <= BLANK;
            digit_cnt   <= 3'd0;
            count_wrong <= 4'd0;
            unlock      <= 1'b0;
            alarm       <= 1'b0;
            busy        <= 1'b0;
            timer       <= '0;
        end else begin
            case (state)
                ENTRY: begin
                    if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            if (digit_cnt != 3'd4) begin
                                seg_4     <= seg_3;
                                seg_3     <= seg_2;
                                seg_2     <= seg_1;
                                seg_1     <= key_code;
                                digit_cnt <= digit_cnt + 3'd1;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            state <= CHECK;
                            busy  <= 1'b1;
                        end else if (key_code == KEY_CLEAR) begin
                            seg_1     <= BLANK;
                            seg_2     <= BLANK;
                            seg_3     <= BLANK;
                            seg_4     <= BLANK;
                            digit_cnt <= 3'd0;
                        end
                    end
                end
                CHECK: begin
                    seg_1     <= BLANK;
                    seg_2     <= BLANK;
                    seg_3     <= BLANK;
                    seg_4     <= BLANK;
                    digit_cnt <= 3'd0;
                    timer     <= '0;
                    if (match_c) begin
                        state       <= OPEN;
                        unlock      <= 1'b1;
                        count_wrong <= 4'd0;
                    end else begin
                        count_wrong <= wrong_inc_c;
                        if (wrong_inc_c == MAX_WRONG_V) begin
                            state <= LOCKOUT;
                            alarm <= 1'b1;
                        end else begin
                            state <= ENTRY;
                            busy  <= 1'b0;
                        end
                    end
                end
                OPEN: begin
                    if (timer == OPEN_LAST) begin
                        state  <= ENTRY;
                        unlock <= 1'b0;
                        busy   <= 1'b0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        state       <= ENTRY;
                        alarm       <= 1'b0;
                        busy        <= 1'b0;
                        count_wrong <= 4'd0;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state       <= ENTRY;
                    seg_1       <= BLANK;
                    seg_2       <= BLANK;
                    seg_3       <= BLANK;
                    seg_4       <= BLANK;
                    digit_cnt   <= 3'd0;
                    count_wrong <= 4'd0;
                    unlock      <= 1'b0;
                    alarm       <= 1'b0;
                    busy        <= 1'b0;
                    timer       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_ctrl.sv
// Scoreboarded bench for lock_ctrl: a key-level model predicts the outputs after
// every clock edge and a monitor compares them against the DUT.
module tb_lock_ctrl;

    localparam int OPEN_C = 8;
    localparam int LOCK_C = 16;
    localparam int MAXW   = 3;

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] s3;
        logic [3:0] s4;
        logic [3:0] cw;
        logic       unl;
        logic       alm;
        logic       bsy;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] seg_1, seg_2, seg_3, seg_4, count_wrong;
    logic       unlock, alarm, busy;

    lock_ctrl #(
        .PASSWORD(16'h1234), .MAX_WRONG(MAXW), .OPEN_CYCLES(OPEN_C), .LOCK_CYCLES(LOCK_C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .seg_1(seg_1), .seg_2(seg_2), .seg_3(seg_3), .seg_4(seg_4),
        .count_wrong(count_wrong), .unlock(unlock), .alarm(alarm), .busy(busy)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    outs_t exp_q[$];

    // Reference model: mode 0 typing, 1 awaiting verdict, 2 open, 3 locked out.
    int    m_mode;
    int    m_digits[$];
    int    m_wrong;
    int    m_remain;
    logic [15:0] pw = 16'h1234;

    function automatic outs_t model_outs();
        outs_t o;
        int    sz = m_digits.size();
        o.s1  = (sz >= 1) ? 4'(m_digits[sz-1]) : 4'hF;
        o.s2  = (sz >= 2) ? 4'(m_digits[sz-2]) : 4'hF;
        o.s3  = (sz >= 3) ? 4'(m_digits[sz-3]) : 4'hF;
        o.s4  = (sz >= 4) ? 4'(m_digits[sz-4]) : 4'hF;
        o.cw  = 4'(m_wrong);
        o.unl = (m_mode == 2);
        o.alm = (m_mode == 3);
        o.bsy = (m_mode != 0);
        return o;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_digits.delete();
        m_wrong = 0;
        m_remain = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] code);
        bit ok;
        case (m_mode)
            0: if (kv) begin
                if (code <= 4'd9) begin
                    if (m_digits.size() < 4) m_digits.push_back(int'(code));
                end else if (code == 4'hA) m_mode = 1;
                else if (code == 4'hB) m_digits.delete();
            end
            1: begin
                ok = (m_digits.size() == 4);
                if (ok)
                    for (int i = 0; i < 4; i++)
                        if (m_digits[i] != int'((pw >> (12 - 4*i)) & 16'hF)) ok = 0;
                m_digits.delete();
                if (ok) begin
                    m_mode = 2; m_remain = OPEN_C; m_wrong = 0;
                end else begin
                    m_wrong++;
                    if (m_wrong == MAXW) begin
                        m_mode = 3; m_remain = LOCK_C;
                    end else m_mode = 0;
                end
            end
            2: begin
                m_remain--;
                if (m_remain == 0) m_mode = 0;
            end
            default: begin
                m_remain--;
                if (m_remain == 0) begin m_mode = 0; m_wrong = 0; end
            end
        endcase
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{seg_1, seg_2, seg_3, seg_4, count_wrong, unlock, alarm, busy};
        return o;
    endfunction

    // Called at a falling edge: drive inputs and queue the response due after the next rise.
    task automatic cycle(input logic kv, input logic [3:0] code);
        key_valid = kv;
        key_code  = code;
        model_step(kv, code);
        exp_q.push_back(model_outs());
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] code);
        cycle(1'b1, code);
        cycle(1'b0, 4'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0);
    endtask

    task automatic do_reset();
        outs_t got;
        outs_t rv;
        rst_n = 1'b0;
        key_valid = 1'b0;
        #1;
        model_reset();
        rv  = model_outs();
        got = dut_outs();
        checks++;
        if (got !== rv) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", got, rv);
        end
        exp_q.push_back(rv);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        key(4'(a)); key(4'(b)); key(4'(c)); key(4'(d)); key(4'hA);
    endtask

    // Monitor: compare every DUT output set with the queued prediction.
    initial begin
        outs_t e;
        outs_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = dut_outs();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got seg=%h%h%h%h cw=%0d u=%b a=%b b=%b exp seg=%h%h%h%h cw=%0d u=%b a=%b b=%b",
                             $time, g.s4, g.s3, g.s2, g.s1, g.cw, g.unl, g.alm, g.bsy,
                             e.s4, e.s3, e.s2, e.s1, e.cw, e.unl, e.alm, e.bsy);
                end
            end
        end
    end

    initial begin
        int r;
        model_reset();
        @(negedge clk);
        do_reset();

        enter4(1, 2, 3, 4); idle(12);
        for (int k = 0; k < 3; k++) begin enter4(1, 2, 3, 5); idle(3); end
        idle(20);
        key(4'd1); key(4'd2); key(4'hA); idle(3);
        key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'd5); idle(2);
        key(4'hB);
        key(4'd7); key(4'hB); enter4(1, 2, 3, 4);
        key(4'd5); key(4'd6); idle(10);
        key(4'd2); idle(2); key(4'hB);

        for (int k = 0; k < 3; k++) begin enter4(0, 0, 0, 0); idle(2); end
        key(4'd3); idle(4);
        do_reset();
        enter4(1, 2, 3, 4); idle(12);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) enter4(1, 2, 3, 4);
            else enter4($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
            idle($urandom_range(0, 10));
        end
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 19);
            if ($urandom_range(0, 2) != 0) cycle(1'b0, 4'(r));
            else if (r < 10) cycle(1'b1, 4'(r));
            else if (r < 14) cycle(1'b1, 4'hA);
            else if (r < 16) cycle(1'b1, 4'hB);
            else cycle(1'b1, 4'($urandom_range(0, 15)));
        end
        idle(2);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
